// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared states, SPART register map and baud divisor function
package spart_pkg;

  typedef enum logic [2:0] {CFG_LO, CFG_HI, RUN, READ, WRITE, HOLD} drv_state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  function automatic logic [15:0] baud_div(input int clk_freq, input logic [1:0] sel);
    int baud;
    int div;
    case (sel)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    div = clk_freq / (16 * baud) - 1;
    return div[15:0];
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// rtl/echo_fifo.sv - small echo FIFO, registered storage with combinational head
module echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: divisor programming then loopback echo
module spart_driver
  import spart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    br_cfg,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic                          cfg_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  drv_state_t state, next_state;
  logic [1:0]  br_meta, br_sync, sel_q, div_sel;
  logic [15:0] div;
  logic        cfg_q;
  logic        acc_c, rd_c, oe_c, push_c, pop_c;
  logic [1:0]  addr_c;
  logic [7:0]  dout_c, fifo_head;
  logic        fifo_full, fifo_empty;

  // Synchronizer keeps sampling through reset so the first divisor after
  // release already reflects the switches.
  always_ff @(posedge clk) begin
    br_meta <= br_cfg;
    br_sync <= br_meta;
  end

  assign div_sel = (state == CFG_LO) ? br_sync : sel_q;
  assign div     = baud_div(CLK_FREQ, div_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CFG_LO;
      sel_q <= 2'b00;
      cfg_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == CFG_LO) sel_q <= br_sync;
      if (state == CFG_LO || state == CFG_HI) cfg_q <= 1'b0;
      else if (state != HOLD) cfg_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    acc_c      = 1'b0;
    rd_c       = 1'b1;
    addr_c     = ADDR_BUF;
    oe_c       = 1'b0;
    dout_c     = 8'h00;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    case (state)
      CFG_LO: begin
        acc_c = 1'b1; rd_c = 1'b0; addr_c = ADDR_DBL; oe_c = 1'b1;
        dout_c = div[7:0];
        next_state = CFG_HI;
      end
      CFG_HI: begin
        acc_c = 1'b1; rd_c = 1'b0; addr_c = ADDR_DBH; oe_c = 1'b1;
        dout_c = div[15:8];
        next_state = HOLD;
      end
      RUN: begin
        if (br_sync != sel_q)         next_state = CFG_LO;
        else if (rda && !fifo_full)   next_state = READ;
        else if (tbr && !fifo_empty)  next_state = WRITE;
      end
      READ: begin
        acc_c = 1'b1; push_c = 1'b1;
        next_state = HOLD;
      end
      WRITE: begin
        acc_c = 1'b1; rd_c = 1'b0; oe_c = 1'b1; pop_c = 1'b1;
        dout_c = fifo_head;
        next_state = HOLD;
      end
      HOLD:    next_state = RUN;
      default: next_state = CFG_LO;
    endcase
  end

  // Gating with rst_n makes a reset mid-access drop the bus immediately.
  assign iocs     = acc_c && rst_n;
  assign iorw     = rd_c || !rst_n;
  assign ioaddr   = rst_n ? addr_c : ADDR_BUF;
  assign databus  = (oe_c && rst_n) ? dout_c : 8'hzz;
  assign cfg_done = rst_n && ((state == RUN) || (state == READ) || (state == WRITE) ||
                              ((state == HOLD) && cfg_q));

  echo_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (databus),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - directed bench with a small SPART bus model
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  wire        iocs, iorw, cfg_done;
  wire  [1:0] ioaddr;
  wire  [7:0] databus;
  wire  [2:0] fifo_cnt;

  logic       tb_oe;
  logic [7:0] tb_val;
  logic [7:0] rx_byte = 8'h00;
  logic       rd_pending = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [9:0] cfg_log[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // The bench plays the SPART: it answers buffer reads and otherwise holds
  // a marker value on the bus whenever the driver must not be driving.
  assign tb_oe   = !(iocs && !iorw);
  assign tb_val  = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hA5;
  assign databus = tb_oe ? tb_val : 8'hzz;

  spart_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_cfg   (br_cfg),
    .rda      (rda),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .cfg_done (cfg_done),
    .fifo_cnt (fifo_cnt)
  );

  always @(negedge clk) begin
    if (rd_pending) begin
      void'(rx_q.pop_front());
      rd_pending = 1'b0;
    end
    rda     = (rx_q.size() != 0);
    rx_byte = rda ? rx_q[0] : 8'h00;
    if (rst_n && iocs && iorw && ioaddr == 2'b00) rd_pending = 1'b1;
    if (rst_n && iocs && !iorw) begin
      if (ioaddr == 2'b00) tx_log.push_back(databus);
      else if (ioaddr[1])  cfg_log.push_back({ioaddr, databus});
    end
  end

  always @(negedge clk) begin
    #1;
    checks++;
    if (tb_oe && databus !== tb_val) begin
      errors++;
      $display("FAIL bus_contention: databus=%h expected %h", databus, tb_val);
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; br_cfg = 2'b01; tbr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (iocs !== 1'b0)     begin errors++; $display("FAIL reset_iocs: got %b exp 0", iocs); end
    checks++; if (iorw !== 1'b1)     begin errors++; $display("FAIL reset_iorw: got %b exp 1", iorw); end
    checks++; if (ioaddr !== 2'b00)  begin errors++; $display("FAIL reset_ioaddr: got %b exp 00", ioaddr); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done: got %b exp 0", cfg_done); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_fifo_cnt: got %0d exp 0", fifo_cnt); end
    checks++; if (databus !== 8'hA5) begin errors++; $display("FAIL reset_databus: got %h exp a5", databus); end
  endtask

  task automatic test_config;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010) begin errors++; $display("FAIL cfg_lo_ctrl: got %b exp 1010", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'h44)  begin errors++; $display("FAIL cfg_lo_data: got %h exp 44", databus); end
    checks++; if (cfg_done !== 1'b0)  begin errors++; $display("FAIL cfg_lo_done: got %b exp 0", cfg_done); end
    @(negedge clk); #1;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1011) begin errors++; $display("FAIL cfg_hi_ctrl: got %b exp 1011", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'h01)  begin errors++; $display("FAIL cfg_hi_data: got %h exp 01", databus); end
    @(negedge clk); #1;
    checks++; if ({iocs, cfg_done} !== 2'b00) begin errors++; $display("FAIL cfg_hold: got %b exp 00", {iocs, cfg_done}); end
    @(negedge clk); #1;
    checks++; if ({iocs, cfg_done} !== 2'b01) begin errors++; $display("FAIL cfg_run: got %b exp 01", {iocs, cfg_done}); end
  endtask

  task automatic test_single_echo;
    @(negedge clk); #1;
    tx_log.delete(); tbr = 1'b1; rx_q.push_back(8'h41);
    @(negedge clk); #1;
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL echo_idle: got %b exp 0", iocs); end
    @(negedge clk); #1;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1100) begin errors++; $display("FAIL echo_read_ctrl: got %b exp 1100", {iocs, iorw, ioaddr}); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL echo_cnt0: got %0d exp 0", fifo_cnt); end
    @(negedge clk); #1;
    checks++; if (fifo_cnt !== 3'd1) begin errors++; $display("FAIL echo_cnt1: got %0d exp 1", fifo_cnt); end
    checks++; if (iocs !== 1'b0)     begin errors++; $display("FAIL echo_hold: got %b exp 0", iocs); end
    @(negedge clk); #1;
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL echo_run_done: got %b exp 1", cfg_done); end
    @(negedge clk); #1;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1000) begin errors++; $display("FAIL echo_write_ctrl: got %b exp 1000", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'h41) begin errors++; $display("FAIL echo_write_data: got %h exp 41", databus); end
    @(negedge clk); #1;
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL echo_cnt_end: got %0d exp 0", fifo_cnt); end
    checks++; if (tx_log.size() != 1) begin errors++; $display("FAIL echo_tx_count: got %0d exp 1", tx_log.size()); end
  endtask

  task automatic test_backpressure;
    @(negedge clk); #1;
    tbr = 1'b0; tx_log.delete();
    for (int i = 0; i < 6; i++) rx_q.push_back(8'h30 + 8'(i));
    repeat (20) @(negedge clk);
    #1;
    checks++; if (fifo_cnt !== 3'd4)  begin errors++; $display("FAIL bp_full: got %0d exp 4", fifo_cnt); end
    checks++; if (rda !== 1'b1)       begin errors++; $display("FAIL bp_rda: got %b exp 1", rda); end
    checks++; if (rx_q.size() != 2)   begin errors++; $display("FAIL bp_held: got %0d exp 2", rx_q.size()); end
    tbr = 1'b1;
    for (int n = 0; n < 200 && !(tx_log.size() == 6 && fifo_cnt == 3'd0); n++) @(negedge clk);
    #1;
    checks++; if (tx_log.size() != 6) begin errors++; $display("FAIL bp_tx_count: got %0d exp 6", tx_log.size()); end
    for (int i = 0; i < 6 && i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL bp_order[%0d]: got %h exp %h", i, tx_log[i], 8'h30 + 8'(i)); end
    end
  endtask

  task automatic test_baud_change;
    logic found;
    @(negedge clk); #1;
    tbr = 1'b0; tx_log.delete();
    rx_q.push_back(8'h61); rx_q.push_back(8'h62);
    repeat (12) @(negedge clk);
    #1;
    checks++; if (fifo_cnt !== 3'd2) begin errors++; $display("FAIL baud_pre_cnt: got %0d exp 2", fifo_cnt); end
    cfg_log.delete(); br_cfg = 2'b11; found = 1'b0;
    for (int n = 0; n < 4 && !found; n++) begin
      @(negedge clk); #1;
      if (iocs && !iorw && ioaddr == 2'b10) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL baud_latency: got %b exp 1", found); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (cfg_log.size() != 2) begin errors++; $display("FAIL baud_writes: got %0d exp 2", cfg_log.size()); end
    else begin
      checks++; if (cfg_log[0] !== 10'h250) begin errors++; $display("FAIL baud_lo: got %h exp 250", cfg_log[0]); end
      checks++; if (cfg_log[1] !== 10'h300) begin errors++; $display("FAIL baud_hi: got %h exp 300", cfg_log[1]); end
    end
    checks++; if (fifo_cnt !== 3'd2) begin errors++; $display("FAIL baud_post_cnt: got %0d exp 2", fifo_cnt); end
    tbr = 1'b1;
    for (int n = 0; n < 50 && tx_log.size() < 2; n++) @(negedge clk);
    #1;
    checks++; if (tx_log.size() != 2) begin errors++; $display("FAIL baud_tx_count: got %0d exp 2", tx_log.size()); end
    else begin
      checks++; if ({tx_log[0], tx_log[1]} !== 16'h6162) begin errors++; $display("FAIL baud_tx_data: got %h%h exp 6162", tx_log[0], tx_log[1]); end
    end
  endtask

  task automatic test_reset_mid_write;
    logic found;
    @(negedge clk); #1;
    tbr = 1'b0; rx_q.push_back(8'h77);
    repeat (6) @(negedge clk);
    #1;
    checks++; if (fifo_cnt !== 3'd1) begin errors++; $display("FAIL rst_pre_cnt: got %0d exp 1", fifo_cnt); end
    tbr = 1'b1; found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk); #1;
      if (iocs && !iorw && ioaddr == 2'b00) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_write_seen: got %b exp 1", found); end
    checks++; if (databus !== 8'h77) begin errors++; $display("FAIL rst_write_data: got %h exp 77", databus); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (iocs !== 1'b0)     begin errors++; $display("FAIL rst_async_iocs: got %b exp 0", iocs); end
    checks++; if (databus !== 8'hA5) begin errors++; $display("FAIL rst_async_bus: got %h exp a5", databus); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if ({iocs, iorw, ioaddr} !== 4'b1010) begin errors++; $display("FAIL rst_cfg_lo_ctrl: got %b exp 1010", {iocs, iorw, ioaddr}); end
    checks++; if (databus !== 8'h50) begin errors++; $display("FAIL rst_cfg_lo_data: got %h exp 50", databus); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL rst_fifo_cnt: got %0d exp 0", fifo_cnt); end
    @(negedge clk); #1;
    checks++; if ({ioaddr, databus} !== 10'h300) begin errors++; $display("FAIL rst_cfg_hi: got %h exp 300", {ioaddr, databus}); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_single_echo();
    test_backpressure();
    test_baud_change();
    test_reset_mid_write();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
